// File: rtl/icache_line.sv
// rtl/icache_line.sv - direct-mapped read-only instruction cache with burst line refill (optional stats: ICACHE_STATS_EN)
module icache_line #(
  parameter int INDEX_BITS      = 6,
  parameter int LINE_WORDS_LOG2 = 2,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_flush,
  input  logic                  cache_valid,
  output logic                  cache_ready,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [31:0]           cache_rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
`ifdef ICACHE_STATS_EN
  ,output logic [31:0]          stat_hits
  ,output logic [31:0]          stat_misses
`endif
);

  localparam int LINES  = 1 << INDEX_BITS;
  localparam int WORDS  = 1 << LINE_WORDS_LOG2;
  localparam int IDX_LO = LINE_WORDS_LOG2 + 2;
  localparam int TAG_LO = IDX_LO + INDEX_BITS;
  localparam int TAG_W  = ADDR_WIDTH - TAG_LO;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                     state_q, state_d;
  logic [LINES-1:0]           valid_q;
  logic [TAG_W-1:0]           tag_ram [LINES];
  logic [31:0]                data_ram [LINES*WORDS];
  logic [TAG_W-1:0]           fill_tag_q, fill_tag_d;
  logic [INDEX_BITS-1:0]      fill_idx_q, fill_idx_d;
  logic [LINE_WORDS_LOG2-1:0] cnt_q, cnt_d;
  logic                       mem_valid_q, mem_valid_d;
  logic                       flush_pend_q, flush_pend_d;

  logic [LINE_WORDS_LOG2-1:0] req_off;
  logic [INDEX_BITS-1:0]      req_idx;
  logic [TAG_W-1:0]           req_tag;
  logic                       hit;
  logic                       start_fill;
  logic                       last_beat;
  logic                       unused_addr_bits;

  assign req_off          = cache_addr[IDX_LO-1:2];
  assign req_idx          = cache_addr[TAG_LO-1:IDX_LO];
  assign req_tag          = cache_addr[ADDR_WIDTH-1:TAG_LO];
  assign unused_addr_bits = ^cache_addr[1:0];

  // Lookup is purely combinational so a hit returns data in the request cycle.
  assign hit         = (state_q == IDLE) && cache_valid && valid_q[req_idx]
                       && (tag_ram[req_idx] == req_tag);
  assign cache_ready = hit;
  assign cache_rdata = data_ram[{req_idx, req_off}];
  assign mem_valid   = mem_valid_q;
  assign mem_addr    = (state_q == FILL) ? {fill_tag_q, fill_idx_q, cnt_q, 2'b00}
                                         : {cache_addr[ADDR_WIDTH-1:2], 2'b00};

  // Refill FSM next-state: a miss launches a burst that always runs to its last beat.
  always_comb begin
    state_d      = state_q;
    fill_tag_d   = fill_tag_q;
    fill_idx_d   = fill_idx_q;
    cnt_d        = cnt_q;
    mem_valid_d  = mem_valid_q;
    flush_pend_d = flush_pend_q;
    start_fill   = 1'b0;
    last_beat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cache_valid && !hit && !cache_flush) begin
          state_d      = FILL;
          fill_tag_d   = req_tag;
          fill_idx_d   = req_idx;
          cnt_d        = '0;
          mem_valid_d  = 1'b1;
          flush_pend_d = 1'b0;
          start_fill   = 1'b1;
        end
      end
      FILL: begin
        if (cache_flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          cnt_d = cnt_q + LINE_WORDS_LOG2'(1);
          if (cnt_q == '1) begin
            last_beat    = 1'b1;
            state_d      = IDLE;
            mem_valid_d  = 1'b0;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and fill bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_tag_q   <= '0;
      fill_idx_q   <= '0;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_tag_q   <= fill_tag_d;
      fill_idx_q   <= fill_idx_d;
      cnt_q        <= cnt_d;
      mem_valid_q  <= mem_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Valid bits: flush wins; a line is validated only if no flush hit it during its burst.
  always_ff @(posedge clk) begin
    if (rst || cache_flush) begin
      valid_q <= '0;
    end else if (start_fill) begin
      valid_q[req_idx] <= 1'b0;
    end else if (last_beat && !flush_pend_q) begin
      valid_q[fill_idx_q] <= 1'b1;
    end
  end

  // Tag/data storage is written by the burst only; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == FILL && mem_ready) begin
      data_ram[{fill_idx_q, cnt_q}] <= mem_rdata;
      if (cnt_q == '1) tag_ram[fill_idx_q] <= fill_tag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;

  // Hit/miss counters, cleared together with the cache contents.
  always_ff @(posedge clk) begin
    if (rst || cache_flush) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (cache_valid && hit) hits_q <= hits_q + 32'd1;
      if (start_fill) misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_icache_line.sv
// tb/tb_icache_line.sv - self-checking bench for icache_line (stats checks when ICACHE_STATS_EN)
module tb_icache_line;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_flush;
  logic        cache_valid;
  logic        cache_ready;
  logic [31:0] cache_addr;
  logic [31:0] cache_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  icache_line dut (
    .clk         (clk),
    .rst         (rst),
    .cache_flush (cache_flush),
    .cache_valid (cache_valid),
    .cache_ready (cache_ready),
    .cache_addr  (cache_addr),
    .cache_rdata (cache_rdata),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,.stat_hits  (stat_hits)
    ,.stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Memory image: word at byte address a is (a/4)+0x60, so 0x100..0x10C hold 0xA0..0xA3.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  // Memory responder: gap idle cycles before every beat, logs each accepted address.
  int          gap = 0;
  int          wait_cnt = 0;
  logic [31:0] beat_log [$];

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    #2;
    if (rst || !mem_valid) begin
      mem_ready = 1'b0;
      wait_cnt  = gap;
    end else if (wait_cnt > 0) begin
      wait_cnt  = wait_cnt - 1;
      mem_ready = 1'b0;
    end else begin
      mem_ready = 1'b1;
      wait_cnt  = gap;
      beat_log.push_back(mem_addr);
    end
    mem_rdata = mem_word(mem_addr);
  end

  // Abstract cache model: which 16-byte line is resident per index, plus an outstanding burst.
  bit          m_v [64];
  logic [27:0] m_line [64];
  bit          m_busy;
  logic [31:0] m_base;
  int          m_beats;
  bit          m_poison;

  function automatic bit m_hit();
    return !m_busy && cache_valid && m_v[cache_addr[9:4]] && (m_line[cache_addr[9:4]] == cache_addr[31:4]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Compare all meaningful outputs with the model at the falling edge.
  task automatic sample();
    logic [31:0] exp_addr;
    @(negedge clk);
    if (!rst) begin
      exp_addr = m_busy ? (m_base + 32'(4 * m_beats)) : {cache_addr[31:2], 2'b00};
      chk("model_ready", 32'(cache_ready), 32'(m_hit()));
      if (m_hit()) chk("model_rdata", cache_rdata, mem_word({cache_addr[31:2], 2'b00}));
      chk("model_mem_valid", 32'(mem_valid), 32'(m_busy));
      chk("model_mem_addr", mem_addr, exp_addr);
    end
  endtask

  // Advance the model by one clock using the inputs of this cycle, then step past the edge.
  task automatic next();
    if (rst) begin
      foreach (m_v[i]) m_v[i] = 1'b0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (cache_flush) begin
        foreach (m_v[i]) m_v[i] = 1'b0;
      end else if (cache_valid && !m_hit()) begin
        m_busy   = 1'b1;
        m_base   = {cache_addr[31:4], 4'h0};
        m_beats  = 0;
        m_poison = 1'b0;
        m_v[cache_addr[9:4]] = 1'b0;
      end
    end else begin
      if (cache_flush) begin
        foreach (m_v[i]) m_v[i] = 1'b0;
        m_poison = 1'b1;
      end
      if (mem_ready) begin
        m_beats++;
        if (m_beats == 4) begin
          m_busy = 1'b0;
          if (!m_poison) begin
            m_v[m_base[9:4]]    = 1'b1;
            m_line[m_base[9:4]] = m_base[31:4];
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // From a sampled request cycle, run until the cache is back in IDLE; lat counts samples.
  task automatic run_fill(output int lat);
    lat = 0;
    do begin
      next();
      sample();
      lat++;
    end while (mem_valid && lat < 200);
    if (mem_valid) $display("FAIL fill_timeout: got mem_valid=1 after %0d cycles expected 0", lat);
    if (mem_valid) n_total++;
  endtask

  task automatic req(input logic [31:0] a);
    cache_valid = 1'b1;
    cache_addr  = a;
  endtask

  int lat;
  int mark;

  initial begin
    rst = 1'b1; cache_flush = 1'b0; cache_valid = 1'b0; cache_addr = '0;
    sample(); next();
    sample(); next();
    rst = 1'b0;
    sample();
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_ready", 32'(cache_ready), 32'd0);
    next();

    // First fill of line 0x100.
    req(32'h100);
    mark = beat_log.size();
    sample();
    chk("first_miss", 32'(cache_ready), 32'd0);
    run_fill(lat);
    chk("miss_latency", 32'(lat), 32'd5);
    chk("beats_0x100", 32'(beat_log.size() - mark), 32'd4);
    for (int i = 0; i < 4; i++) chk("beat_addr_0x100", beat_log[mark + i], 32'h100 + 32'(4 * i));
    chk("hit_0x100", 32'(cache_ready), 32'd1);
    chk("rdata_0x100", cache_rdata, 32'hA0);
    next();
    for (int i = 1; i < 4; i++) begin
      req(32'h100 + 32'(4 * i));
      sample();
      chk("hit_word", 32'(cache_ready), 32'd1);
      chk("rdata_word", cache_rdata, 32'hA0 + 32'(i));
      chk("hit_no_mem", 32'(mem_valid), 32'd0);
      next();
    end

    // Conflict miss on index 0x10.
    req(32'h500);
    sample();
    chk("conflict_miss", 32'(cache_ready), 32'd0);
    run_fill(lat);
    chk("rdata_0x500", cache_rdata, 32'h1A0);
    next();
    req(32'h100);
    sample();
    chk("evicted_0x100", 32'(cache_ready), 32'd0);
    run_fill(lat);
    next();

    // Three stall cycles before every beat.
    gap = 3;
    req(32'h30C);
    sample();
    run_fill(lat);
    chk("stall_latency", 32'(lat), 32'd17);
    chk("stall_rdata", cache_rdata, 32'h123);
    next();
    gap = 0;

    // Flush on the second beat of a fill to 0x200.
    req(32'h200);
    mark = beat_log.size();
    sample(); next();
    sample(); next();
    cache_flush = 1'b1;
    sample(); next();
    cache_flush = 1'b0;
    run_fill(lat);
    chk("flush_beats", 32'(beat_log.size() - mark), 32'd4);
    chk("flush_not_valid", 32'(cache_ready), 32'd0);
    next();
    sample();
    chk("refill_after_flush", 32'(mem_valid), 32'd1);
    run_fill(lat);
    chk("rdata_0x200", cache_rdata, 32'hE0);
    next();

    // Flush on the final beat of a fill to 0x240.
    req(32'h240);
    sample(); next();
    sample(); next();
    sample(); next();
    sample(); next();
    cache_flush = 1'b1;
    sample(); next();
    cache_flush = 1'b0;
    sample();
    chk("last_beat_flush", 32'(cache_ready), 32'd0);
    run_fill(lat);
    next();

    // Flush in IDLE has priority over a concurrent miss.
    req(32'h600);
    cache_flush = 1'b1;
    sample(); next();
    cache_flush = 1'b0;
    sample();
    chk("flush_blocks_fill", 32'(mem_valid), 32'd0);
    run_fill(lat);
    next();

    // Reset in the middle of a burst.
    req(32'h700);
    sample();
    run_fill(lat);
    chk("rdata_0x700", cache_rdata, 32'h220);
    next();
    req(32'h740);
    sample(); next();
    sample(); next();
    rst = 1'b1;
    sample(); next();
    rst = 1'b0;
    req(32'h700);
    sample();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_lost_line", 32'(cache_ready), 32'd0);
    run_fill(lat);
    next();

`ifdef ICACHE_STATS_EN
    cache_valid = 1'b0;
    cache_flush = 1'b1;
    sample(); next();
    cache_flush = 1'b0;
    req(32'h800);
    sample();
    run_fill(lat);
    next();
    req(32'h804);
    sample(); next();
    req(32'h808);
    sample(); next();
    cache_valid = 1'b0;
    sample();
    chk("stat_misses", stat_misses, 32'd1);
    chk("stat_hits", stat_hits, 32'd3);
    next();
    cache_flush = 1'b1;
    sample(); next();
    cache_flush = 1'b0;
    sample();
    chk("stat_misses_clr", stat_misses, 32'd0);
    chk("stat_hits_clr", stat_hits, 32'd0);
    next();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icache_line.md
Name: icache_line

Overview:
- Direct-mapped, read-only instruction cache with multi-word lines and burst refill.
- Successor to the single-word fetch cache; sits between the core fetch stage and the instruction memory bus.
- Stores a partial tag per line, not the full address.
- Refill is a sequential burst of LINE_WORDS single-word memory reads, controlled by an explicit FSM.
- Flush is safe to assert in the middle of a refill.

Parameters:
- INDEX_BITS, 6: log2 of the number of lines (64 lines).
- LINE_WORDS_LOG2, 2: log2 of words per line (4 words, 16 bytes per line).
- ADDR_WIDTH, 32: byte address width. Tag width is ADDR_WIDTH-INDEX_BITS-LINE_WORDS_LOG2-2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cache_flush  in  1  invalidate all lines.
- cache_valid  in  1  fetch request valid.
- cache_ready  out  1  hit: cache_rdata is valid this cycle.
- cache_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- cache_rdata  out  32  instruction word.
- mem_valid  out  1  memory read request.
- mem_ready  in  1  memory read data valid; one beat per cycle.
- mem_addr  out  ADDR_WIDTH  word-aligned memory read address.
- mem_rdata  in  32  memory read data.

Behaviour:
- Address split:
  - off = addr[LINE_WORDS_LOG2+1:2]
  - idx = next INDEX_BITS bits
  - tag = remaining upper bits
- Storage per line: valid bit, tag, and LINE_WORDS data words.
- Data RAM reads are asynchronous (combinational).
- Reset: valid[] all 0, state=IDLE, mem_valid=0, fill counter=0. Tag/data RAM contents are not reset.
- Hit: cache_ready = (state==IDLE) && cache_valid && valid[idx] && tag_ram[idx]==tag.
  - Combinational, zero-latency.
  - cache_rdata = data_ram[idx][off]. Value is don't-care when cache_ready=0.
- States: IDLE, FILL.
- IDLE -> FILL on miss (cache_valid && !hit && !cache_flush):
  - Latch fill_tag and fill_idx from cache_addr.
  - Clear valid[fill_idx].
  - Set counter=0 and mem_valid=1.
- In FILL:
  - mem_addr = {fill_tag, fill_idx, counter, 2'b00}.
  - In IDLE, mem_addr = cache_addr word-aligned.
  - On each cycle with mem_ready=1:
    - Write mem_rdata to data_ram[fill_idx][counter].
    - Increment counter, which wraps modulo LINE_WORDS.
  - On the beat where counter==LINE_WORDS-1 and mem_ready=1:
    - Write tag_ram[fill_idx]=fill_tag.
    - Set valid[fill_idx]=1 unless flush_pend.
    - Clear mem_valid and flush_pend.
    - Go to IDLE.
- mem_valid stays 1 for the whole FILL, including cycles where mem_ready=0. Stalls are unbounded.
- Miss latency: LINE_WORDS beats plus 1 cycle. A hit is available in the first IDLE cycle after the fill completes.
- cache_ready is 0 throughout FILL, even for addresses that would otherwise hit.
- Changes to cache_valid or cache_addr during FILL do not affect the burst in progress.
  - The same address re-presented after the fill then hits.
- Flush in IDLE: valid[] all 0 next cycle. Flush has priority, so no fill starts in that cycle.
- Flush during FILL:
  - valid[] all 0.
  - Burst runs to completion because memory requests cannot be cancelled.
  - flush_pend is set, and the filled line is not validated.
- Flush on the same cycle as the final beat: the line is not validated.
- Reset mid-FILL: the next cycle is IDLE with mem_valid=0. Any remaining memory beats are ignored.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, adds two outputs:
  - stat_hits  out  32: increments on each cycle with cache_valid && cache_ready.
  - stat_misses  out  32: increments on each IDLE->FILL transition.
- Both counters wrap at 2^32, reset to 0 on rst, and are cleared by cache_flush.
- When not defined: ports absent, no counter logic, behaviour otherwise identical.

Test Plan:
- Reset, then cache_valid=1, addr=0x100, memory returns 0xA0,0xA1,0xA2,0xA3 for 0x100..0x10C:
  - mem_addr steps 0x100, 0x104, 0x108, 0x10C.
  - After completion, cache_ready=1 with rdata=0xA0.
  - Requests to 0x104, 0x108, 0x10C hit with 0xA1, 0xA2, 0xA3 and mem_valid=0.
- Conflict miss:
  - After filling 0x100, request 0x500 (same idx 0x10, different tag): a refill starts.
  - Then 0x100 misses again.
- mem_ready stalls of 3 cycles between beats:
  - mem_valid held at 1 and mem_addr stable during stalls.
  - Data correct after the fill.
- cache_flush asserted on the second beat of a fill to 0x200:
  - Burst still issues 4 reads.
  - Next request to 0x200 misses and triggers a new fill.
- rst asserted mid-fill:
  - Next cycle mem_valid=0 and state is IDLE.
  - Request to the previously filled address misses.
- ICACHE_STATS_EN defined: 1 miss followed by 3 hits gives stat_misses=1 and stat_hits=3. A subsequent flush clears both to 0.
